pipeline_flush_sequencer: RTL and testbench

- Sequences multi-cycle pipeline squashes, load-use stalls and interrupt entry for the 5-stage core.
- Consumes the combinational hazard requests (flush request, flush count, PC-source request, bubble) plus an external interrupt.
- Converts them into timed, mutually exclusive per-stage flush, stall and PC-control strobes.
- Sits between the hazard detection logic and the PC, the pipeline registers and the control-unit NOP mux.

---
 rtl/pipeline_flush_sequencer_pkg.sv | 40 ++++
 rtl/pipeline_flush_sequencer_if.sv | 33 +++
 rtl/pipeline_flush_sequencer_flush_counter.sv | 36 +++
 rtl/pipeline_flush_sequencer.sv | 117 +++++++++++
 tb/tb_pipeline_flush_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_flush_sequencer_pkg.sv
// Shared encodings for the pipeline flush sequencer: FSM states, PC-source
// selects and the registered control-output bundle with its idle value.
package pipeline_flush_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2,
    ST_INT   = 2'd3
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_REG = 2'b01;
  localparam logic [1:0] PCSRC_MEM = 2'b10;
  localparam logic [1:0] PCSRC_INT = 2'b11;

  typedef struct packed {
    logic [1:0] pc_src;
    logic       pc_write_en;
    logic       if_id_write_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ctrl_nop;
    logic       int_ack;
    logic       busy;
  } ctrl_t;

  // Free-running pipeline: sequential PC, all registers loading, nothing squashed.
  localparam ctrl_t CTRL_IDLE = '{
    pc_src:         PCSRC_SEQ,
    pc_write_en:    1'b1,
    if_id_write_en: 1'b1,
    if_id_flush:    1'b0,
    id_ex_flush:    1'b0,
    ctrl_nop:       1'b0,
    int_ack:        1'b0,
    busy:           1'b0
  };

endpackage

// File: rtl/pipeline_flush_sequencer_if.sv
// Hazard-request inputs and pipeline-control strobes of the flush sequencer.
// There is no valid/ready handshake: requests are levels sampled every edge.
interface pipeline_flush_sequencer_if;
  import pipeline_flush_sequencer_pkg::*;

  logic       flush_req;
  logic [1:0] flush_num;
  logic [1:0] pc_src_req;
  logic       bubble_req;
  logic       int_req;

  logic [1:0] pc_src;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ctrl_nop;
  logic       int_ack;
  logic       busy;
  state_t     dbg_state;

  modport master (
    output flush_req, flush_num, pc_src_req, bubble_req, int_req,
    input  pc_src, pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
           ctrl_nop, int_ack, busy, dbg_state
  );

  modport slave (
    input  flush_req, flush_num, pc_src_req, bubble_req, int_req,
    output pc_src, pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
           ctrl_nop, int_ack, busy, dbg_state
  );
endinterface

// File: rtl/pipeline_flush_sequencer_flush_counter.sv
// Loadable 3-bit down-counter timing FLUSH and INT; saturates at zero and
// also exports its next value so the owner can register outputs from it.
module pipeline_flush_sequencer_flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] count_next,
  output logic       last
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;
  assign last       = (count_q == 3'd1);

endmodule

// File: rtl/pipeline_flush_sequencer.sv
// Turns hazard requests into timed, mutually exclusive flush/stall/PC strobes
// for the 5-stage core. Every output is registered alongside the FSM state.
module pipeline_flush_sequencer
  import pipeline_flush_sequencer_pkg::*;
#(
  parameter int         INT_CYCLES = 2,
  parameter logic [1:0] PC_SRC_INT = PCSRC_INT
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_flush_sequencer_if.slave    bus
);

  localparam logic [2:0] INT_LOAD = 3'(INT_CYCLES);

  state_t     state_q, state_d;
  ctrl_t      out_q, out_d;
  logic       cnt_load;
  logic [2:0] cnt_val;
  logic       cnt_dec;
  logic [2:0] cnt_next;
  logic       cnt_last;
  logic       entering_flush;

  pipeline_flush_sequencer_flush_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_val   (cnt_val),
    .dec        (cnt_dec),
    .count_next (cnt_next),
    .last       (cnt_last)
  );

  // Requests are only honoured in IDLE; while FLUSH runs they come from
  // instructions that are being squashed anyway.
  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_val        = 3'd0;
    cnt_dec        = 1'b0;
    entering_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d        = ST_FLUSH;
          cnt_load       = 1'b1;
          cnt_val        = (bus.flush_num == 2'd0) ? 3'd1 : {1'b0, bus.flush_num};
          entering_flush = 1'b1;
        end else if (bus.bubble_req) begin
          state_d = ST_STALL;
        end else if (bus.int_req) begin
          state_d  = ST_INT;
          cnt_load = 1'b1;
          cnt_val  = INT_LOAD;
        end
      end
      ST_FLUSH, ST_INT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs for the coming cycle, derived from the next state and count.
  always_comb begin
    out_d = CTRL_IDLE;
    case (state_d)
      ST_FLUSH: begin
        out_d.pc_src      = entering_flush ? bus.pc_src_req : PCSRC_SEQ;
        out_d.if_id_flush = 1'b1;
        out_d.id_ex_flush = 1'b1;
        out_d.ctrl_nop    = 1'b1;
      end
      ST_STALL: begin
        out_d.pc_write_en    = 1'b0;
        out_d.if_id_write_en = 1'b0;
        out_d.id_ex_flush    = 1'b1;
        out_d.ctrl_nop       = 1'b1;
      end
      ST_INT: begin
        out_d.if_id_write_en = 1'b0;
        out_d.if_id_flush    = 1'b1;
        out_d.pc_write_en    = (cnt_next == 3'd1);
        out_d.int_ack        = (cnt_next == 3'd1);
        out_d.pc_src         = (cnt_next == 3'd1) ? PC_SRC_INT : PCSRC_SEQ;
      end
      default: out_d = CTRL_IDLE;
    endcase
    out_d.busy = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.pc_src         = out_q.pc_src;
  assign bus.pc_write_en    = out_q.pc_write_en;
  assign bus.if_id_write_en = out_q.if_id_write_en;
  assign bus.if_id_flush    = out_q.if_id_flush;
  assign bus.id_ex_flush    = out_q.id_ex_flush;
  assign bus.ctrl_nop       = out_q.ctrl_nop;
  assign bus.int_ack        = out_q.int_ack;
  assign bus.busy           = out_q.busy;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_pipeline_flush_sequencer.sv
// Directed bench for pipeline_flush_sequencer: a cycle-by-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_pipeline_flush_sequencer;
  import pipeline_flush_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_flush_sequencer_if bus ();

  pipeline_flush_sequencer #(
    .INT_CYCLES (2),
    .PC_SRC_INT (2'b11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic started = 1'b0;

  // Expected output word: {pc_src, pc_we, ifid_we, ifid_flush, idex_flush, nop, ack, busy}
  localparam logic [8:0] O_IDLE  = {2'b00, 7'b1100000};
  localparam logic [8:0] O_FL    = {2'b00, 7'b1111101};
  localparam logic [8:0] O_STALL = {2'b00, 7'b0001101};
  localparam logic [8:0] O_INTM  = {2'b00, 7'b0010001};
  localparam logic [8:0] O_INTL  = {2'b11, 7'b1010011};

  function automatic logic [8:0] o_ff(input logic [1:0] p);
    return {p, 7'b1111101};
  endfunction

  typedef struct {
    logic       rst;
    logic       flush_req;
    logic [1:0] flush_num;
    logic [1:0] pc_src_req;
    logic       bubble_req;
    logic       int_req;
    logic [8:0] exp;
  } vec_t;

  localparam int NV = 39;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, input logic f, input logic [1:0] n,
                              input logic [1:0] s, input logic b, input logic i,
                              input logic [8:0] e);
    vec_t v;
    v.rst = r; v.flush_req = f; v.flush_num = n; v.pc_src_req = s;
    v.bubble_req = b; v.int_req = i; v.exp = e;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.pc_src, bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush,
            bus.id_ex_flush, bus.ctrl_nop, bus.int_ack, bus.busy};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t exp);
    n_checks++;
    if (bus.dbg_state !== exp) begin
      n_fail++;
      $display("FAIL %s: state got %0d expected %0d", name, bus.dbg_state, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic f, input logic [1:0] n,
                       input logic [1:0] s, input logic b, input logic i);
    rst = r; bus.flush_req = f; bus.flush_num = n; bus.pc_src_req = s;
    bus.bubble_req = b; bus.int_req = i;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // The shared counter must never exceed the largest load value.
  always @(negedge clk) begin
    if (started && !rst) begin
      n_checks++;
      if (dut.u_cnt.count_next > 3'd3) begin
        n_fail++;
        $display("FAIL count_range: got %0d expected <= 3", dut.u_cnt.count_next);
      end
    end
  end

  initial begin
    int busy_cnt;
    int ack_cnt;

    //             rst f  num    src    b  i  expected
    vt[0]  = mk(1, 0, 2'd0, 2'b00, 0, 0, O_IDLE);       // reset
    vt[1]  = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[2]  = mk(0, 1, 2'd1, 2'b01, 0, 0, o_ff(2'b01));  // JMP
    vt[3]  = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[4]  = mk(0, 1, 2'd3, 2'b10, 0, 0, o_ff(2'b10));  // RTI
    vt[5]  = mk(0, 1, 2'd1, 2'b01, 0, 0, O_FL);         // ignored pulse
    vt[6]  = mk(0, 1, 2'd1, 2'b01, 0, 1, O_FL);         // ignored pulse + int
    vt[7]  = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[8]  = mk(0, 0, 2'd0, 2'b00, 1, 0, O_STALL);      // load-use
    vt[9]  = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[10] = mk(0, 1, 2'd2, 2'b01, 1, 0, o_ff(2'b01));  // flush beats bubble
    vt[11] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_FL);
    vt[12] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[13] = mk(0, 0, 2'd0, 2'b00, 1, 0, O_STALL);      // held bubble
    vt[14] = mk(0, 0, 2'd0, 2'b00, 1, 0, O_IDLE);
    vt[15] = mk(0, 0, 2'd0, 2'b00, 1, 0, O_STALL);
    vt[16] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[17] = mk(0, 1, 2'd0, 2'b10, 0, 0, o_ff(2'b10));  // flush_num 0 -> 1 cycle
    vt[18] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[19] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_INTM);       // interrupt
    vt[20] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_INTL);
    vt[21] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[22] = mk(0, 0, 2'd0, 2'b00, 1, 1, O_STALL);      // bubble beats int
    vt[23] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_IDLE);
    vt[24] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_INTM);
    vt[25] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_INTL);
    vt[26] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[27] = mk(0, 1, 2'd3, 2'b01, 0, 0, o_ff(2'b01));  // reset mid-flush
    vt[28] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_FL);
    vt[29] = mk(1, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[30] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);
    vt[31] = mk(0, 1, 2'd1, 2'b01, 0, 1, o_ff(2'b01));  // flush beats int
    vt[32] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_IDLE);
    vt[33] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_INTM);
    vt[34] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_INTL);
    vt[35] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_IDLE);       // int still high
    vt[36] = mk(0, 0, 2'd0, 2'b00, 0, 1, O_INTM);       // re-serviced
    vt[37] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_INTL);
    vt[38] = mk(0, 0, 2'd0, 2'b00, 0, 0, O_IDLE);

    drive(1, 0, 2'd0, 2'b00, 0, 0);
    @(negedge clk);
    started = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].flush_req, vt[i].flush_num, vt[i].pc_src_req,
            vt[i].bubble_req, vt[i].int_req);
      tick();
      check($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // int_req raised during a 2-cycle flush is taken right after it
    drive(0, 1, 2'd2, 2'b10, 0, 1);
    tick(); check("seq_int_fl1", outs(), o_ff(2'b10)); check_state("seq_int_fl1_st", ST_FLUSH);
    drive(0, 0, 2'd0, 2'b00, 0, 1);
    tick(); check("seq_int_fl2", outs(), O_FL);
    tick(); check("seq_int_idle", outs(), O_IDLE);  check_state("seq_int_idle_st", ST_IDLE);
    tick(); check("seq_int_c1", outs(), O_INTM);    check_state("seq_int_c1_st", ST_INT);
    drive(0, 0, 2'd0, 2'b00, 0, 0);
    tick(); check("seq_int_c2", outs(), O_INTL);
    tick(); check("seq_int_done", outs(), O_IDLE);

    // RTI: busy for exactly 3 cycles, flush pulses inside it ignored, no ack
    busy_cnt = 0;
    ack_cnt  = 0;
    drive(0, 1, 2'd3, 2'b10, 0, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.int_ack) ack_cnt++;
      drive(0, (c < 2) ? 1'b1 : 1'b0, 2'd3, 2'b01, 0, 0);
    end
    check_int("rti_busy_cycles", busy_cnt, 3);
    check_int("rti_no_ack", ack_cnt, 0);

    // ---------------- report ----------------
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
